// File: rtl/riscv_pkg.sv
// Shared core types and constants for the fetch front end.
// Pure declarations; no logic, no latency, no flow control.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of any incoming PC are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head read straight from storage, push-to-head 1 cycle.
// Push at full is accepted only together with a pop; flush overrides push and pop.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns fetch PC, one outstanding imem request, buffers {pc, instr}.
// Accept-to-valid 2 cycles; requests only issued while FIFO slots cover all outstanding returns.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall,
  output logic                   valid_out,
  output logic [XLEN-1:0]        pc_out,
  output logic [XLEN-1:0]        instruction_out,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            discard;

  logic [AW:0]     count;
  logic            empty;
  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;

  // An outstanding request reserves a slot, so its return can always be pushed.
  assign credit_ok = ((count + (AW+1)'(inflight)) < (AW+1)'(DEPTH));
  assign imem_req  = !reset && !redirect && credit_ok;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_gnt;

  assign push     = inflight && !discard && !redirect;
  assign pop      = valid_out && !stall && !redirect;
  assign wr_entry = '{pc: inflight_pc, instruction: imem_rdata};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_entry),
    .count     (count),
    .empty     (empty)
  );

  assign valid_out       = !empty;
  assign pc_out          = valid_out ? head_entry.pc : '0;
  assign instruction_out = valid_out ? head_entry.instruction : '0;
  assign level           = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      discard     <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= align_pc(redirect_pc);
        // A return landing in this cycle is flushed with the queue; only a request
        // accepted now would come back after the flush and needs marking.
        discard  <= accept;
      end else begin
        if (accept) begin
          fetch_pc <= next_pc(fetch_pc);
        end
        if (inflight) begin
          discard <= 1'b0;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    push |-> (count < (AW+1)'(DEPTH)) || pop);

  assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_gnt) |=> (imem_addr == $past(imem_addr)) && (imem_req || redirect));

  assert property (@(posedge clk) disable iff (reset)
    imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, mid-stream async reset, then randomized
// traffic against a queue-based reference model with a responding instruction memory.
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [2:0]  level;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .level           (level)
  );

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] rpc;
    logic        g;
    logic        st;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [2:0]  e_lvl;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic        resp_pending;
  logic [31:0] resp_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_C013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the memory answers a request accepted last cycle.
  task automatic drive(input logic rst, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic st);
    @(negedge clk);
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = g;
    stall       = st;
    imem_rdata  = resp_pending ? instr_of(resp_addr) : $urandom;
    #1;
  endtask

  task automatic latch_resp();
    resp_pending = imem_req && imem_gnt && !reset;
    resp_addr    = imem_addr;
  endtask

  task automatic check_outputs(input string tag, input logic e_vld, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic [2:0] e_lvl,
                               input logic e_req, input logic [31:0] e_addr);
    chk({tag, ".valid_out"}, {31'b0, valid_out}, {31'b0, e_vld});
    chk({tag, ".pc_out"}, pc_out, e_pc);
    chk({tag, ".instruction_out"}, instruction_out, e_instr);
    chk({tag, ".level"}, {29'b0, level}, {29'b0, e_lvl});
    chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk({tag, ".imem_addr"}, imem_addr, e_addr);
  endtask

  task automatic add_v(input logic rst, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic st, input logic e_vld,
                       input logic [31:0] e_pc, input logic [2:0] e_lvl,
                       input logic e_req, input logic [31:0] e_addr);
    vec_t v;
    v = '{rst, rd, rpc, g, st, e_vld, e_pc, e_lvl, e_req, e_addr};
    vt.push_back(v);
  endtask

  fetch_entry_t m_q[$];
  fetch_entry_t m_e;
  logic [31:0]  m_fpc;
  logic [31:0]  m_ppc;
  logic         m_pend;
  logic         r_rd, r_g, r_st, e_req;
  logic [31:0]  r_rpc;
  logic [31:0]  e_pc, e_in;

  initial begin
    reset        = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = '0;
    imem_gnt     = 1'b0;
    stall        = 1'b0;
    imem_rdata   = '0;
    resp_pending = 1'b0;
    resp_addr    = '0;

    //    rst   rd    rpc           g     st    vld   pc            lvl   req   addr
    add_v(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 32'h0);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h0);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h4);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        3'd1, 1'b1, 32'h8);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h4,        3'd1, 1'b1, 32'hC);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h8,        3'd1, 1'b1, 32'h10);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        3'd1, 1'b1, 32'h14);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        3'd2, 1'b1, 32'h18);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        3'd3, 1'b0, 32'h1C);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        3'd4, 1'b0, 32'h1C);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        3'd4, 1'b0, 32'h1C);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC,        3'd4, 1'b0, 32'h1C);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h10,       3'd3, 1'b1, 32'h1C);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h14,       3'd2, 1'b1, 32'h20);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h18,       3'd2, 1'b1, 32'h24);
    add_v(1'b0, 1'b1, 32'h103,      1'b1, 1'b0, 1'b1, 32'h1C,       3'd2, 1'b0, 32'h0);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h100);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h104);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h100,      3'd1, 1'b1, 32'h108);
    add_v(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h104,      3'd1, 1'b1, 32'h10C);
    add_v(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h108,      3'd1, 1'b1, 32'h10C);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h10C);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h110);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h10C,      3'd1, 1'b1, 32'h114);
    add_v(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h110,     3'd1, 1'b0, 32'h0);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'hFFFF_FFFC);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h0);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 3'd1, 1'b1, 32'h4);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        3'd1, 1'b1, 32'h8);
    add_v(1'b0, 1'b1, 32'h200,      1'b1, 1'b0, 1'b1, 32'h4,        3'd1, 1'b0, 32'h0);
    add_v(1'b0, 1'b1, 32'h301,      1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 32'h0);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h300);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 32'h304);
    add_v(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h300,      3'd1, 1'b1, 32'h308);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].rd, vt[i].rpc, vt[i].g, vt[i].st);
      check_outputs($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_pc,
                    vt[i].e_vld ? instr_of(vt[i].e_pc) : 32'h0,
                    vt[i].e_lvl, vt[i].e_req, vt[i].e_addr);
      latch_resp();
    end

    // Fill to level 3 under stall, then hit async reset mid-cycle with a return pending.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    latch_resp();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    latch_resp();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("pre_reset.level", {29'b0, level}, 32'd3);
    chk("pre_reset.pc_out", pc_out, 32'h304);
    #1 reset = 1'b1;
    #1;
    check_outputs("async_reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
    latch_resp();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check_outputs("reset_hold", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
    latch_resp();

    // Randomized traffic from reset release; model tracks the expected instruction stream.
    m_q.delete();
    m_fpc  = 32'h0;
    m_ppc  = 32'h0;
    m_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r_rd  = (c >= 3) && ($urandom_range(0, 31) == 0);
      r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      r_g   = (c < 3) || ($urandom_range(0, 3) != 0);
      if (c < 3) r_st = 1'b0;
      else if (((c / 400) % 2) == 1) r_st = ($urandom_range(0, 9) < 7);
      else r_st = ($urandom_range(0, 9) < 2);

      e_req = !r_rd && ((m_q.size() + int'(m_pend)) < DEPTH);
      e_pc  = (m_q.size() != 0) ? m_q[0].pc : 32'h0;
      e_in  = (m_q.size() != 0) ? m_q[0].instruction : 32'h0;

      drive(1'b0, r_rd, r_rpc, r_g, r_st);
      check_outputs($sformatf("rand%0d", c), m_q.size() != 0, e_pc, e_in,
                    3'(m_q.size()), e_req, m_fpc);
      latch_resp();

      if (r_rd) begin
        m_q.delete();
        m_pend = 1'b0;
        m_fpc  = {r_rpc[31:2], 2'b00};
      end else begin
        if (m_q.size() != 0 && !r_st) void'(m_q.pop_front());
        if (m_pend) begin
          m_e.pc          = m_ppc;
          m_e.instruction = instr_of(m_ppc);
          m_q.push_back(m_e);
        end
        if (e_req && r_g) begin
          m_pend = 1'b1;
          m_ppc  = m_fpc;
          m_fpc  = m_fpc + 32'd4;
        end else begin
          m_pend = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
